// File: rtl/line_mem_responder.sv
// Line-granular memory responder: one storage array serving an ifetch port and a data port,
// one transaction at a time with fixed latency. Define ARB_RR_EN for round-robin arbitration.
module line_mem_responder #(
    parameter int LATENCY    = 3,
    parameter int DEPTH_LOG2 = 8
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         ifetch_read,
    input  logic [11:0]  ifetch_address,
    output logic [127:0] ifetch_rdata,
    output logic         ifetch_resp,
    input  logic         mem_read,
    input  logic         mem_write,
    input  logic [11:0]  mem_address,
    input  logic [127:0] mem_wdata,
    input  logic [15:0]  mem_sel,
    output logic [127:0] mem_rdata,
    output logic         mem_resp
);
    localparam int CNT_W = (LATENCY > 1) ? $clog2(LATENCY) : 1;
    localparam int DEPTH = 1 << DEPTH_LOG2;

    typedef enum logic [1:0] {IDLE, BUSY, RESP} state_t;

    state_t                state_q, state_d;
    logic [CNT_W-1:0]      cnt_q, cnt_d;
    logic                  port_q, port_d;
    logic                  wr_q, wr_d;
    logic [DEPTH_LOG2-1:0] idx_q, idx_d;
    logic [127:0]          wdata_q, wdata_d;
    logic [15:0]           sel_q, sel_d;
    logic                  ifetch_resp_q, ifetch_resp_d;
    logic                  mem_resp_q, mem_resp_d;
    logic [127:0]          ifetch_rdata_q, ifetch_rdata_d;
    logic [127:0]          mem_rdata_q, mem_rdata_d;
`ifdef ARB_RR_EN
    logic                  prio_data_q, prio_data_d;
`endif

    logic [127:0] mem_array [DEPTH];

    logic                  mem_req, grant_data, accept, enter_resp, commit_we;
    logic                  new_wr;
    logic [DEPTH_LOG2-1:0] new_idx;
    logic                  cur_data, cur_wr;
    logic [DEPTH_LOG2-1:0] cur_idx;
    logic [127:0]          cur_wdata;
    logic [15:0]           cur_sel;
    logic                  unused_addr;

    assign unused_addr = ^{ifetch_address[11:DEPTH_LOG2], mem_address[11:DEPTH_LOG2]};

    assign mem_req = mem_read | mem_write;
`ifdef ARB_RR_EN
    assign grant_data = mem_req & (~ifetch_read | prio_data_q);
`else
    assign grant_data = mem_req;
`endif
    assign accept  = (state_q == IDLE) & (mem_req | ifetch_read);
    assign new_wr  = grant_data & mem_write;
    assign new_idx = grant_data ? mem_address[DEPTH_LOG2-1:0] : ifetch_address[DEPTH_LOG2-1:0];

    // With single-cycle latency the commit happens on the accepting edge, straight from the ports.
    assign cur_data  = accept ? grant_data : port_q;
    assign cur_wr    = accept ? new_wr     : wr_q;
    assign cur_idx   = accept ? new_idx    : idx_q;
    assign cur_wdata = accept ? mem_wdata  : wdata_q;
    assign cur_sel   = accept ? mem_sel    : sel_q;

    assign enter_resp = (LATENCY == 1) ? accept
                                       : ((state_q == BUSY) && (cnt_q == CNT_W'(1)));
    assign commit_we  = enter_resp & cur_wr;

    always_comb begin
        // NOTE: every variable gets a default first so no latch is inferred.
        state_d        = state_q;
        cnt_d          = cnt_q;
        port_d         = port_q;
        wr_d           = wr_q;
        idx_d          = idx_q;
        wdata_d        = wdata_q;
        sel_d          = sel_q;
        ifetch_resp_d  = 1'b0;
        mem_resp_d     = 1'b0;
        ifetch_rdata_d = ifetch_rdata_q;
        mem_rdata_d    = mem_rdata_q;
`ifdef ARB_RR_EN
        prio_data_d    = accept ? ~grant_data : prio_data_q;
`endif

        case (state_q)
            IDLE: begin
                if (accept) begin
                    port_d  = grant_data;
                    wr_d    = new_wr;
                    idx_d   = new_idx;
                    wdata_d = mem_wdata;
                    sel_d   = mem_sel;
                    if (LATENCY == 1) begin
                        state_d = RESP;
                    end else begin
                        state_d = BUSY;
                        cnt_d   = CNT_W'(LATENCY - 1);
                    end
                end
            end
            BUSY: begin
                cnt_d = cnt_q - CNT_W'(1);
                if (cnt_q == CNT_W'(1)) state_d = RESP;
            end
            RESP:    state_d = IDLE;
            default: state_d = IDLE;
        endcase

        if (enter_resp) begin
            if (cur_data) begin
                mem_resp_d = 1'b1;
                if (!cur_wr) mem_rdata_d = mem_array[cur_idx];
            end else begin
                ifetch_resp_d  = 1'b1;
                ifetch_rdata_d = mem_array[cur_idx];
            end
        end
    end

    // NOTE: sequential state uses non-blocking assignments only.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q        <= IDLE;
            cnt_q          <= '0;
            port_q         <= 1'b0;
            wr_q           <= 1'b0;
            idx_q          <= '0;
            wdata_q        <= '0;
            sel_q          <= '0;
            ifetch_resp_q  <= 1'b0;
            mem_resp_q     <= 1'b0;
            ifetch_rdata_q <= '0;
            mem_rdata_q    <= '0;
`ifdef ARB_RR_EN
            prio_data_q    <= 1'b1;
`endif
        end else begin
            state_q        <= state_d;
            cnt_q          <= cnt_d;
            port_q         <= port_d;
            wr_q           <= wr_d;
            idx_q          <= idx_d;
            wdata_q        <= wdata_d;
            sel_q          <= sel_d;
            ifetch_resp_q  <= ifetch_resp_d;
            mem_resp_q     <= mem_resp_d;
            ifetch_rdata_q <= ifetch_rdata_d;
            mem_rdata_q    <= mem_rdata_d;
`ifdef ARB_RR_EN
            prio_data_q    <= prio_data_d;
`endif
        end
    end

    // NOTE: the storage array is deliberately not reset; it behaves as plain RAM.
    always_ff @(posedge clk) begin
        if (commit_we) begin
            for (int b = 0; b < 16; b++) begin
                if (cur_sel[b]) mem_array[cur_idx][8*b +: 8] <= cur_wdata[8*b +: 8];
            end
        end
    end

    assign ifetch_resp  = ifetch_resp_q;
    assign mem_resp     = mem_resp_q;
    assign ifetch_rdata = ifetch_rdata_q;
    assign mem_rdata    = mem_rdata_q;
endmodule

// File: tb/tb_line_mem_responder.sv
// Bench for line_mem_responder: transaction-level model plus directed vectors (LATENCY=3 main
// instance, LATENCY=1 instance for the streaming case).
module tb_line_mem_responder;
    localparam int LAT = 3;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    logic         ifetch_read = 0, mem_read = 0, mem_write = 0;
    logic [11:0]  ifetch_address = 0, mem_address = 0;
    logic [127:0] mem_wdata = 0;
    logic [15:0]  mem_sel = 0;
    logic [127:0] ifetch_rdata, mem_rdata;
    logic         ifetch_resp, mem_resp;

    logic         d1_ifetch_read = 0, d1_mem_read = 0, d1_mem_write = 0;
    logic [11:0]  d1_ifetch_address = 0, d1_mem_address = 0;
    logic [127:0] d1_mem_wdata = 0;
    logic [15:0]  d1_mem_sel = 0;
    logic [127:0] d1_ifetch_rdata, d1_mem_rdata;
    logic         d1_ifetch_resp, d1_mem_resp;

    line_mem_responder #(.LATENCY(LAT), .DEPTH_LOG2(8)) u_dut (
        .clk(clk), .rst_n(rst_n),
        .ifetch_read(ifetch_read), .ifetch_address(ifetch_address),
        .ifetch_rdata(ifetch_rdata), .ifetch_resp(ifetch_resp),
        .mem_read(mem_read), .mem_write(mem_write), .mem_address(mem_address),
        .mem_wdata(mem_wdata), .mem_sel(mem_sel),
        .mem_rdata(mem_rdata), .mem_resp(mem_resp)
    );

    line_mem_responder #(.LATENCY(1), .DEPTH_LOG2(8)) u_dut1 (
        .clk(clk), .rst_n(rst_n),
        .ifetch_read(d1_ifetch_read), .ifetch_address(d1_ifetch_address),
        .ifetch_rdata(d1_ifetch_rdata), .ifetch_resp(d1_ifetch_resp),
        .mem_read(d1_mem_read), .mem_write(d1_mem_write), .mem_address(d1_mem_address),
        .mem_wdata(d1_mem_wdata), .mem_sel(d1_mem_sel),
        .mem_rdata(d1_mem_rdata), .mem_resp(d1_mem_resp)
    );

    int n_checks = 0;
    int n_pass   = 0;
    bit chk_en   = 0;

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h", name, act, exp);
    endtask

    task automatic check_int(input string name, input int act, input int exp);
        n_checks++;
        if (act == exp) n_pass++;
        else $display("FAIL %s: got %0d expected %0d", name, act, exp);
    endtask

    // Transaction-level model: tracks edge numbers, acceptance window and the commit edge.
    bit [127:0]   m_mem [256];
    int           m_edge = 0, m_free = 0, m_commit = 0;
    bit           m_pend = 0, m_data = 0, m_wr = 0, m_prio_data = 1;
    int           m_idx = 0;
    logic [127:0] m_wdata = 0;
    logic [15:0]  m_sel = 0;
    logic         exp_ifetch_resp = 0, exp_mem_resp = 0;
    logic [127:0] exp_ifetch_rdata = 0, exp_mem_rdata = 0;

    initial forever begin
        @(posedge clk or negedge rst_n);
        if (!rst_n) begin
            m_pend = 0; m_free = 0; m_prio_data = 1;
            exp_ifetch_resp = 0; exp_mem_resp = 0;
            exp_ifetch_rdata = 0; exp_mem_rdata = 0;
        end else begin
            m_edge++;
            exp_ifetch_resp = 0;
            exp_mem_resp    = 0;
            if (!m_pend && m_edge >= m_free && (ifetch_read || mem_read || mem_write)) begin
`ifdef ARB_RR_EN
                m_data = (mem_read || mem_write) && (!ifetch_read || m_prio_data);
`else
                m_data = mem_read || mem_write;
`endif
                m_prio_data = !m_data;
                m_pend   = 1;
                m_wr     = m_data && mem_write;
                m_idx    = m_data ? int'(mem_address) % 256 : int'(ifetch_address) % 256;
                m_wdata  = mem_wdata;
                m_sel    = mem_sel;
                m_commit = m_edge + LAT - 1;
            end
            if (m_pend && m_edge == m_commit) begin
                if (m_data) begin
                    exp_mem_resp = 1;
                    if (m_wr) begin
                        for (int b = 0; b < 16; b++)
                            if (m_sel[b]) m_mem[m_idx][8*b +: 8] = m_wdata[8*b +: 8];
                    end else begin
                        exp_mem_rdata = m_mem[m_idx];
                    end
                end else begin
                    exp_ifetch_resp  = 1;
                    exp_ifetch_rdata = m_mem[m_idx];
                end
                m_pend = 0;
                m_free = m_edge + 2;
            end
        end
    end

    always @(negedge clk) begin
        if (chk_en) begin
            check("cmp_ifetch_resp", {127'd0, ifetch_resp}, {127'd0, exp_ifetch_resp});
            check("cmp_mem_resp", {127'd0, mem_resp}, {127'd0, exp_mem_resp});
            check("cmp_ifetch_rdata", ifetch_rdata, exp_ifetch_rdata);
            check("cmp_mem_rdata", mem_rdata, exp_mem_rdata);
        end
    end

    task automatic mem_txn(input logic rd, input logic wr, input logic [11:0] a,
                           input logic [127:0] wd, input logic [15:0] s, output int lat);
        @(negedge clk);
        mem_read = rd; mem_write = wr; mem_address = a; mem_wdata = wd; mem_sel = s;
        lat = -1;
        for (int i = 1; i <= 20; i++) begin
            @(negedge clk);
            if (mem_resp) begin
                lat = i;
                break;
            end
        end
        mem_read = 0; mem_write = 0;
    endtask

    task automatic d1_write(input logic [11:0] a, input logic [127:0] d);
        int lat;
        @(negedge clk);
        d1_mem_write = 1; d1_mem_address = a; d1_mem_wdata = d; d1_mem_sel = 16'hFFFF;
        lat = -1;
        for (int i = 1; i <= 10; i++) begin
            @(negedge clk);
            if (d1_mem_resp) begin
                lat = i;
                break;
            end
        end
        d1_mem_write = 0;
        check_int("d1_write_latency", lat, 1);
    endtask

    function automatic logic [127:0] line_pat(input int k);
        return {4{32'hC0DE0000 | 32'(k)}};
    endfunction

    localparam logic [127:0] D1     = 128'h0123456789ABCDEF0123456789ABCDEF;
    localparam logic [127:0] FILL_A = 128'hAAAAAAAA_AAAAAAAA_AAAAAAAA_AAAAAAAA;
    localparam logic [127:0] MERGED = 128'hAAAAAAAA_AAAAAAAA_AAAAAAAA_AAAA1234;
    localparam logic [127:0] P0     = 128'h55555555_55555555_55555555_55555555;
    localparam logic [127:0] D3     = 128'hDEADBEEF_CAFEF00D_01020304_A5A5A5A5;
    localparam logic [127:0] D4     = 128'h11112222_33334444_55556666_77778888;

    initial begin
        int lat, mem_t, if_t, got, prev, cyc;
        bit saw;

        repeat (2) @(negedge clk);
        check("reset_mem_resp", {127'd0, mem_resp}, 128'd0);
        check("reset_ifetch_resp", {127'd0, ifetch_resp}, 128'd0);
        check("reset_mem_rdata", mem_rdata, 128'd0);
        check("reset_ifetch_rdata", ifetch_rdata, 128'd0);
        rst_n = 1;
        chk_en = 1;

        // Latency and read-back
        mem_txn(0, 1, 12'h005, D1, 16'hFFFF, lat);
        check_int("write_latency", lat, 3);
        @(negedge clk);
        check("resp_one_cycle", {127'd0, mem_resp}, 128'd0);
        mem_txn(1, 0, 12'h005, 128'd0, 16'h0, lat);
        check_int("read_latency", lat, 3);
        check("readback_005", mem_rdata, D1);

        // Byte merge
        mem_txn(0, 1, 12'h010, FILL_A, 16'hFFFF, lat);
        mem_txn(0, 1, 12'h010, 128'h1234, 16'h0003, lat);
        mem_txn(1, 0, 12'h010, 128'd0, 16'h0, lat);
        check("byte_merge", mem_rdata, MERGED);

        // Contention: data port wins, ifetch follows LAT+1 cycles later
        @(negedge clk);
        ifetch_address = 12'h005; mem_address = 12'h020;
        mem_address = 12'h010;
        ifetch_read = 1; mem_read = 1;
        mem_t = -1; if_t = -1;
        for (int i = 1; i <= 30 && (mem_t < 0 || if_t < 0); i++) begin
            @(negedge clk);
            if (mem_resp && mem_t < 0) begin mem_t = i; mem_read = 0; end
            if (ifetch_resp && if_t < 0) begin if_t = i; ifetch_read = 0; end
        end
        mem_read = 0; ifetch_read = 0;
        check_int("contention_mem_first", mem_t, 3);
        check_int("contention_gap", if_t - mem_t, LAT + 1);
        check("contention_ifetch_data", ifetch_rdata, D1);
        check("contention_mem_data", mem_rdata, MERGED);

        // Reset abort during BUSY
        mem_txn(0, 1, 12'h020, P0, 16'hFFFF, lat);
        @(negedge clk);
        mem_write = 1; mem_address = 12'h020; mem_wdata = '1; mem_sel = 16'hFFFF;
        @(negedge clk);
        #2 rst_n = 0;
        mem_write = 0;
        #1;
        check("abort_mem_resp", {127'd0, mem_resp}, 128'd0);
        check("abort_mem_rdata", mem_rdata, 128'd0);
        check("abort_ifetch_rdata", ifetch_rdata, 128'd0);
        @(negedge clk);
        #2 rst_n = 1;
        saw = 0;
        repeat (6) begin
            @(negedge clk);
            if (mem_resp || ifetch_resp) saw = 1;
        end
        check_int("abort_no_resp", int'(saw), 0);
        mem_txn(1, 0, 12'h020, 128'd0, 16'h0, lat);
        check("abort_prior_contents", mem_rdata, P0);

        // Aliasing and read+write together
        mem_txn(0, 1, 12'h105, D3, 16'hFFFF, lat);
        mem_txn(1, 0, 12'h005, 128'd0, 16'h0, lat);
        check("alias_read", mem_rdata, D3);
        mem_txn(1, 1, 12'h005, D4, 16'hFFFF, lat);
        check_int("rdwr_resp_latency", lat, 3);
        check("rdwr_rdata_unchanged", mem_rdata, D3);
        mem_txn(1, 0, 12'h005, 128'd0, 16'h0, lat);
        check("rdwr_write_done", mem_rdata, D4);

        // Zero byte-select write still responds, changes nothing
        mem_txn(0, 1, 12'h010, 128'd0, 16'h0000, lat);
        check_int("sel0_resp_latency", lat, 3);
        mem_txn(1, 0, 12'h010, 128'd0, 16'h0, lat);
        check("sel0_unchanged", mem_rdata, MERGED);

        // Streaming ifetch on the LATENCY=1 instance
        for (int k = 0; k < 8; k++) d1_write(12'(k), line_pat(k));
        @(negedge clk);
        d1_ifetch_address = 12'h000;
        d1_ifetch_read = 1;
        cyc = 0; prev = 0;
        for (int k = 0; k < 8; k++) begin
            got = -1;
            for (int i = 1; i <= 10; i++) begin
                @(negedge clk);
                cyc++;
                if (d1_ifetch_resp) begin
                    got = cyc;
                    break;
                end
            end
            if (k == 0) check_int("stream_first_latency", got, 1);
            else        check_int("stream_gap", got - prev, 2);
            check("stream_line", d1_ifetch_rdata, line_pat(k));
            prev = got;
            d1_ifetch_address = 12'(k + 1);
        end
        d1_ifetch_read = 0;
        check("stream_line7_literal", d1_ifetch_rdata, 128'hC0DE0007_C0DE0007_C0DE0007_C0DE0007);

        repeat (3) @(negedge clk);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end
endmodule
